// File: rtl/attendant_station_controller_pkg.sv
// Shared types and default sizing for the attendant station controller.
package attendant_station_controller_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ALERT     = 2'd1,
        SERVICING = 2'd2,
        CLEAR     = 2'd3
    } state_t;

    localparam int unsigned DEF_N_SEATS         = 8;
    localparam int unsigned DEF_SEAT_W          = 3;
    localparam int unsigned DEF_CNT_W           = 4;
    localparam int unsigned DEF_CHIME_CYCLES    = 4;
    localparam int unsigned DEF_ESCALATE_CYCLES = 1000;

endpackage

// File: rtl/attendant_station_controller_rr_seat_picker.sv
// Round-robin request picker: first set request at or after ptr, wrapping.
module rr_seat_picker
    import attendant_station_controller_pkg::*;
#(
    parameter int unsigned N_SEATS = DEF_N_SEATS,
    parameter int unsigned SEAT_W  = DEF_SEAT_W
) (
    input  logic [N_SEATS-1:0] req,
    input  logic [SEAT_W-1:0]  ptr,
    output logic [SEAT_W-1:0]  grant_idx,
    output logic               grant_any
);

    logic              found;
    logic [SEAT_W-1:0] cand;

    always_comb begin
        grant_any = |req;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < N_SEATS; i++) begin
            cand = SEAT_W'((32'(ptr) + i) % N_SEATS);
            if (!found && req[cand]) begin
                grant_idx = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/attendant_station_controller.sv
// Attendant-side call responder: round-robin call selection, chime,
// escalation timer and one-cycle cancel pulse back to the served seat.
module attendant_station_controller
    import attendant_station_controller_pkg::*;
#(
    parameter int unsigned N_SEATS         = DEF_N_SEATS,
    parameter int unsigned SEAT_W          = DEF_SEAT_W,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned CHIME_CYCLES    = DEF_CHIME_CYCLES,
    parameter int unsigned ESCALATE_CYCLES = DEF_ESCALATE_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SEATS-1:0] seat_light,
    input  logic               ack_button,
    input  logic               done_button,
    output logic [N_SEATS-1:0] cancel_out,
    output logic [SEAT_W-1:0]  active_seat,
    output logic               active_valid,
    output logic               chime,
    output logic               escalate,
    output logic [CNT_W-1:0]   pending_count
);

    localparam int unsigned CHIME_W = $clog2(CHIME_CYCLES + 1);
    localparam int unsigned WAIT_W  = $clog2(ESCALATE_CYCLES + 1);

    state_t             state, next_state;
    logic [SEAT_W-1:0]  rr_ptr, next_ptr, grant_idx;
    logic               grant_any;
    logic               entering_alert, light_dropped;
    logic [CHIME_W-1:0] chime_left;
    logic [WAIT_W-1:0]  wait_cnt, wait_next;
    logic [N_SEATS-1:0] seat_onehot;
    logic [CNT_W-1:0]   light_count;

    rr_seat_picker #(
        .N_SEATS (N_SEATS),
        .SEAT_W  (SEAT_W)
    ) picker (
        .req       (seat_light),
        .ptr       (rr_ptr),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        next_state     = state;
        entering_alert = 1'b0;
        light_dropped  = !seat_light[active_seat];
        case (state)
            IDLE: begin
                if (grant_any) begin
                    next_state     = ALERT;
                    entering_alert = 1'b1;
                end
            end
            // a passenger cancel beats a simultaneous ack
            ALERT: begin
                if (light_dropped)   next_state = IDLE;
                else if (ack_button) next_state = SERVICING;
            end
            SERVICING: if (done_button) next_state = CLEAR;
            CLEAR:     next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        next_ptr = (active_seat == SEAT_W'(N_SEATS - 1)) ? '0 : active_seat + 1'b1;
        if (wait_cnt == WAIT_W'(ESCALATE_CYCLES)) wait_next = wait_cnt;
        else                                      wait_next = wait_cnt + 1'b1;
        seat_onehot              = '0;
        seat_onehot[active_seat] = 1'b1;
        light_count              = '0;
        for (int unsigned i = 0; i < N_SEATS; i++) begin
            light_count = light_count + CNT_W'(seat_light[i]);
        end
    end

    // Outputs are registered from next_state so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            active_seat   <= '0;
            active_valid  <= 1'b0;
            chime         <= 1'b0;
            chime_left    <= '0;
            wait_cnt      <= '0;
            escalate      <= 1'b0;
            cancel_out    <= '0;
            pending_count <= '0;
        end else begin
            state         <= next_state;
            active_valid  <= (next_state != IDLE);
            pending_count <= light_count;
            cancel_out    <= (next_state == CLEAR) ? seat_onehot : '0;
            if (entering_alert) begin
                active_seat <= grant_idx;
                chime       <= 1'b1;
                chime_left  <= CHIME_W'(CHIME_CYCLES - 1);
                wait_cnt    <= WAIT_W'(1);
                escalate    <= 1'b0;
            end else if (next_state == ALERT) begin
                chime    <= (chime_left != '0);
                if (chime_left != '0) chime_left <= chime_left - 1'b1;
                wait_cnt <= wait_next;
                escalate <= (wait_next == WAIT_W'(ESCALATE_CYCLES));
            end else begin
                chime    <= 1'b0;
                escalate <= 1'b0;
            end
            if ((state == CLEAR) || (state == ALERT && light_dropped)) begin
                rr_ptr <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_attendant_station_controller.sv
// Self-checking bench: fixed vector table, directed multi-cycle sequences
// and randomized traffic against a call-level reference model.
module tb_attendant_station_controller;

    localparam int unsigned N     = 8;
    localparam int unsigned SW    = 3;
    localparam int unsigned CW    = 4;
    localparam int unsigned CHIME = 4;
    localparam int unsigned ESC   = 1000;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  seat_light;
    logic          ack_button, done_button;
    logic [N-1:0]  cancel_out;
    logic [SW-1:0] active_seat;
    logic          active_valid, chime, escalate;
    logic [CW-1:0] pending_count;

    always #5 clk = ~clk;

    attendant_station_controller #(
        .N_SEATS         (N),
        .SEAT_W          (SW),
        .CNT_W           (CW),
        .CHIME_CYCLES    (CHIME),
        .ESCALATE_CYCLES (ESC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .seat_light    (seat_light),
        .ack_button    (ack_button),
        .done_button   (done_button),
        .cancel_out    (cancel_out),
        .active_seat   (active_seat),
        .active_valid  (active_valid),
        .chime         (chime),
        .escalate      (escalate),
        .pending_count (pending_count)
    );

    int    checks   = 0;
    int    failures = 0;
    string tag      = "init";

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: one call record (displayed / accepted / clearing)
    // plus elapsed ALERT cycles; outputs follow from these directly.
    bit          m_busy, m_acked, m_clearing;
    int unsigned m_seat, m_ptr, m_age, m_pend;

    function automatic logic [N-1:0] exp_cancel();
        logic [N-1:0] v;
        v = '0;
        if (m_clearing) v[m_seat] = 1'b1;
        return v;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_busy = 0; m_acked = 0; m_clearing = 0;
            m_seat = 0; m_ptr = 0; m_age = 0; m_pend = 0;
        end else begin
            m_pend = $countones(seat_light);
            if (!m_busy) begin
                for (int unsigned off = 0; off < N; off++) begin
                    if (seat_light[(m_ptr + off) % N]) begin
                        m_seat = (m_ptr + off) % N;
                        m_busy = 1; m_acked = 0; m_clearing = 0; m_age = 1;
                        break;
                    end
                end
            end else if (m_clearing) begin
                m_busy = 0; m_clearing = 0; m_ptr = (m_seat + 1) % N;
            end else if (m_acked) begin
                if (done_button) m_clearing = 1;
            end else if (!seat_light[m_seat]) begin
                m_busy = 0; m_ptr = (m_seat + 1) % N;
            end else if (ack_button) begin
                m_acked = 1;
            end else begin
                m_age++;
            end
        end
    endtask

    // Seat-unit emulation: light latches call, clears on cancel or passenger drop.
    bit           auto_seats = 0;
    logic [N-1:0] call = '0;
    logic [N-1:0] drop = '0;

    task automatic tick();
        logic [N-1:0] nxt;
        nxt = ((seat_light | call) & ~drop) & ~exp_cancel();
        model_step();
        @(posedge clk);
        #1;
        if (auto_seats) seat_light = nxt;
        drop = '0;
    endtask

    task automatic compare_model();
        bit alerting;
        alerting = m_busy && !m_acked && !m_clearing;
        check({tag, ".valid"},    32'(active_valid),  32'(m_busy));
        check({tag, ".seat"},     32'(active_seat),   m_seat);
        check({tag, ".chime"},    32'(chime),         32'(alerting && (m_age <= CHIME)));
        check({tag, ".escalate"}, 32'(escalate),      32'(alerting && (m_age >= ESC)));
        check({tag, ".cancel"},   32'(cancel_out),    32'(exp_cancel()));
        check({tag, ".pending"},  32'(pending_count), m_pend);
    endtask

    task automatic tick_chk();
        tick();
        compare_model();
    endtask

    task automatic do_reset();
        reset = 1; ack_button = 0; done_button = 0; call = '0; drop = '0;
        tick_chk();
        tick_chk();
        reset = 0;
    endtask

    task automatic serve(input int exp_seat, input int relight, output int unsigned pend_seen);
        int n;
        logic [N-1:0] one;
        n = 0;
        while (!active_valid && n < 40) begin
            tick_chk();
            n++;
        end
        check({tag, ".alert_reached"}, 32'(active_valid), 1);
        check({tag, ".served_seat"}, 32'(active_seat), exp_seat);
        pend_seen = 32'(pending_count);
        if (relight >= 0) call[relight] = 1'b1;
        ack_button = 1; tick_chk(); ack_button = 0;
        if (relight >= 0) call[relight] = 1'b0;
        done_button = 1; tick_chk(); done_button = 0;
        one = '0;
        one[exp_seat] = 1'b1;
        check({tag, ".cancel_pulse"}, 32'(cancel_out), 32'(one));
        tick_chk();
        check({tag, ".cancel_once"}, 32'(cancel_out), 0);
        check({tag, ".back_idle"}, 32'(active_valid), 0);
    endtask

    typedef struct {
        bit           rst;
        logic [N-1:0] light;
        bit           ack, done;
        bit           valid;
        int unsigned  seat;
        bit           chm, esc;
        logic [N-1:0] cancel;
        int unsigned  pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input logic [N-1:0] light, input bit ack, input bit done,
                       input bit valid, input int unsigned seat, input bit chm,
                       input logic [N-1:0] cancel, input int unsigned pend);
        vec_t v;
        v.rst = rst; v.light = light; v.ack = ack; v.done = done;
        v.valid = valid; v.seat = seat; v.chm = chm; v.esc = 1'b0;
        v.cancel = cancel; v.pend = pend;
        vecs.push_back(v);
    endtask

    initial begin
        int unsigned p;
        int          cyc;
        reset = 1; seat_light = '0; ack_button = 0; done_button = 0;

        //   rst light   ack done | valid seat chime cancel pend
        add(1, 8'h00, 0, 0,   0, 0, 0, 8'h00, 0);
        add(0, 8'h20, 0, 0,   1, 5, 1, 8'h00, 1);
        add(0, 8'h20, 0, 0,   1, 5, 1, 8'h00, 1);
        add(0, 8'h20, 0, 0,   1, 5, 1, 8'h00, 1);
        add(0, 8'h20, 0, 0,   1, 5, 1, 8'h00, 1);
        add(0, 8'h20, 0, 0,   1, 5, 0, 8'h00, 1);
        add(0, 8'h20, 1, 0,   1, 5, 0, 8'h00, 1);
        add(0, 8'h20, 0, 1,   1, 5, 0, 8'h20, 1);
        add(0, 8'h20, 0, 0,   0, 5, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0,   0, 5, 0, 8'h00, 0);
        add(0, 8'h10, 0, 0,   1, 4, 1, 8'h00, 1);
        add(0, 8'h00, 1, 0,   0, 4, 0, 8'h00, 0);
        add(0, 8'h30, 0, 0,   1, 5, 1, 8'h00, 2);
        add(0, 8'h00, 0, 0,   0, 5, 0, 8'h00, 0);
        add(0, 8'h00, 1, 1,   0, 5, 0, 8'h00, 0);

        tick();
        tick();
        foreach (vecs[i]) begin
            reset = vecs[i].rst; seat_light = vecs[i].light;
            ack_button = vecs[i].ack; done_button = vecs[i].done;
            tick();
            tag = $sformatf("vec%0d", i);
            check({tag, ".valid"},    32'(active_valid),  32'(vecs[i].valid));
            check({tag, ".seat"},     32'(active_seat),   vecs[i].seat);
            check({tag, ".chime"},    32'(chime),         32'(vecs[i].chm));
            check({tag, ".escalate"}, 32'(escalate),      32'(vecs[i].esc));
            check({tag, ".cancel"},   32'(cancel_out),    32'(vecs[i].cancel));
            check({tag, ".pending"},  32'(pending_count), vecs[i].pend);
        end
        ack_button = 0; done_button = 0;

        // Three seats at once, seat 2 re-lights while seat 3 is serviced.
        tag = "rr"; auto_seats = 1; seat_light = '0;
        do_reset();
        call = 8'b0100_1100; tick_chk(); call = '0;
        serve(2, -1, p);
        serve(3, 2, p);
        serve(6, -1, p);
        serve(2, -1, p);

        // Unacknowledged call escalates on its 1000th ALERT cycle and holds.
        tag = "esc";
        do_reset();
        call[1] = 1'b1; tick_chk(); call = '0;
        cyc = 0;
        while (!active_valid && cyc < 10) begin tick_chk(); cyc++; end
        check("esc.alert_reached", 32'(active_valid), 1);
        cyc = 1;
        while (!escalate && cyc < 1100) begin tick_chk(); cyc++; end
        check("esc.first_cycle", cyc, ESC);
        repeat (40) tick_chk();
        check("esc.held", 32'(escalate), 1);
        ack_button = 1; tick_chk(); ack_button = 0;
        check("esc.dropped_by_ack", 32'(escalate), 0);
        done_button = 1; tick_chk(); done_button = 0;
        tick_chk();

        // Reset in the middle of servicing seat 7; the call is re-presented.
        tag = "rst";
        do_reset();
        call[7] = 1'b1;
        cyc = 0;
        while (!active_valid && cyc < 10) begin tick_chk(); cyc++; end
        check("rst.first_seat", 32'(active_seat), 7);
        ack_button = 1; tick_chk(); ack_button = 0;
        call = '0;
        reset = 1; tick_chk(); reset = 0;
        check("rst.valid", 32'(active_valid), 0);
        check("rst.seat", 32'(active_seat), 0);
        check("rst.chime", 32'(chime), 0);
        check("rst.cancel", 32'(cancel_out), 0);
        check("rst.pending", 32'(pending_count), 0);
        check("rst.light_kept", 32'(seat_light[7]), 1);
        serve(7, -1, p);

        // Wrap-around: advance pointer to 7, then seats 0 and 7 together.
        tag = "wrap";
        do_reset();
        call[6] = 1'b1; tick_chk(); call = '0;
        serve(6, -1, p);
        call = 8'b1000_0001; tick_chk(); call = '0;
        serve(7, -1, p);
        check("wrap.pending_two", p, 2);
        serve(0, -1, p);
        check("wrap.pending_one", p, 1);
        tick_chk();
        check("wrap.pending_zero", 32'(pending_count), 0);

        // Randomized traffic, checked every cycle against the model.
        tag = "rand";
        do_reset();
        for (int unsigned i = 0; i < 4000; i++) begin
            for (int unsigned s = 0; s < N; s++) begin
                call[s] = ($urandom_range(0, 31) == 0);
                drop[s] = ($urandom_range(0, 63) == 0);
            end
            ack_button  = ($urandom_range(0, 3) == 0);
            done_button = ($urandom_range(0, 3) == 0);
            reset       = ($urandom_range(0, 699) == 0);
            tick_chk();
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
